matrix_scan_decoder: RTL and testbench
======================================

# matrix_scan_decoder

Monitor-side decoder for the irrigation controller's 5×7 LED matrix. It samples the multiplexed column/row lines that the matrix drivers produce and rebuilds the full 35-pixel frame. It then checks that the column scan sequence is legal, classifies the frame against the known glyph set (level, critical, error, pump state), and reports a stable symbol code. It sits between the matrix driver outputs and the supervisory/self-test logic, as the receiving end of the scan interface.

## Interface
- SETTLE_CYC, 4: consecutive cycles a column must be stable before its rows are captured (≥1)
- TIMEOUT_CYC, 1024: maximum cycles without a column transition while capturing
- STABLE_FRAMES, 2: consecutive identical frames required to confirm a symbol (≥1)
- clk  in  1  system clock
- rstn  in  1  asynchronous, active-low reset
- col_i  in  5  column lines, bit0 = column 1, active-high, one-hot or all-zero (gap)
- lin_i  in  7  row lines, bit0 = row 1, active-high
- frame_o  out  35  last complete frame, bits [7c+6:7c] = rows of column c+1
- frame_valid  out  1  one-cycle pulse when frame_o updates
- symbol  out  4  confirmed glyph code
- symbol_valid  out  1  symbol is confirmed and scan is healthy
- scan_err  out  1  one-cycle pulse on illegal sequence, multi-hot column or timeout

## Operation
- Glyph codes and row masks (rows 1..7, bit0 = column 1):
  - 0 BLANK: all 00
  - 1 LVL_LOW: 1F×6, 00
  - 2 LVL_MED: 1F,1F,1F,00,1F,1F,00
  - 3 LVL_HIGH: 00,1F,1F,00,1F,1F,00
  - 4 CRIT: 00,1E,1E,00,1E,1E,00
  - 5 ERR: 00,1E,1E,1E,1E,1E,00
  - 6 PUMP_A: 00,0E,0E,0E,00,0E,0E
  - 7 PUMP_G: 00,1E,1E,06,0E,0E,00
  - 8 PUMP_OFF: 00,0E,0E,0E,0E,0E,00
  - F UNKNOWN: any other frame
- Column qualifier: a column value (after optional sync) that is unchanged for SETTLE_CYC cycles is "qualified". Glitches shorter than SETTLE_CYC are ignored. An all-zero value is a gap; gaps are legal between columns and are never captured.
- A multi-hot column that stays stable for SETTLE_CYC cycles produces scan_err and returns the FSM to HUNT.
- FSM:
  - HUNT: wait for qualified column 1.
  - CAPTURE(k): expects qualified column k+1. On that column, latch lin_i into shadow slot k+1. Re-qualifying the same column is ignored. Any other qualified column → scan_err, discard shadow, HUNT.
  - Column 5 captured → COMMIT.
  - COMMIT (1 cycle): copy shadow to frame_o, pulse frame_valid, run match logic, go to HUNT.
- Timeout: a cycle counter (width clog2(TIMEOUT_CYC+1)) clears on every column value change. Reaching TIMEOUT_CYC in CAPTURE → scan_err, symbol_valid=0, HUNT. The counter is inactive in HUNT.
- Match logic: if the new frame equals the previous frame_o, match_cnt saturates-increments; otherwise match_cnt=1. When match_cnt reaches STABLE_FRAMES, symbol=decode(frame) and symbol_valid=1. Until then, symbol holds its prior value.
- scan_err clears symbol_valid and match_cnt. symbol itself is kept.

## Timing
- Reset values: frame_o=0, frame_valid=0, symbol=0, symbol_valid=0, scan_err=0, match_cnt=0, FSM=HUNT.
- Input path: 2 cycles with the sync stage, 0 without.
- Capture occurs on the SETTLE_CYC-th consecutive cycle of the stable column.
- frame_valid is asserted the cycle after the column-5 capture. symbol/symbol_valid update in that same cycle.
- scan_err and frame_valid never coincide. Timeout wins over a column change in the same cycle.
- rstn asserted mid-frame discards the shadow immediately. The first frame after reset must start at column 1.

## Configuration
- MATRIX_SYNC_EN defined: col_i and lin_i pass through 2-flop synchronizers (asynchronous driver clock).
- Not defined: inputs are sampled directly (same clock domain), and input latency is 0.

## Structure
- Package matrix_pkg: glyph code enum, the 9 glyph row-mask constants, NCOL=5, NROW=7, and a decode function (frame → code).
- Sub-module scan_qualifier: settle counter, gap/multi-hot classification, and the qualified-column strobe. The FSM, timeout and match logic stay in the top.

## Test plan
- LVL_LOW scanned twice (SETTLE_CYC=4, 2 gap steps per frame) → two frame_valid pulses; symbol=1 and symbol_valid=1 at the second.
- Steady LVL_LOW, then switch to PUMP_A → symbol stays 1 at the first PUMP_A frame and becomes 6 at the second.
- Column order 1,2,4 → scan_err pulse at column 4, no frame_valid, symbol_valid=0. A following clean frame is accepted.
- Hold column 3 for TIMEOUT_CYC cycles → scan_err exactly at timeout, symbol_valid=0.
- 2-cycle glitch to column 5 during column 2 → ignored, frame completes normally. Non-table pattern → symbol=F.
- rstn low during column 3 → all outputs at reset values. Scanning starting at column 2 yields no frame until column 1 appears.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and glyph tables for the 5x7 LED matrix scan decoder.
// Glyph masks are listed row 7 first so row 1 lands in the low bits.
package matrix_pkg;

    localparam int NCOL = 5;
    localparam int NROW = 7;
    localparam int NPIX = NCOL * NROW;

    typedef enum logic [3:0] {
        GLYPH_BLANK    = 4'h0,
        GLYPH_LVL_LOW  = 4'h1,
        GLYPH_LVL_MED  = 4'h2,
        GLYPH_LVL_HIGH = 4'h3,
        GLYPH_CRIT     = 4'h4,
        GLYPH_ERR      = 4'h5,
        GLYPH_PUMP_A   = 4'h6,
        GLYPH_PUMP_G   = 4'h7,
        GLYPH_PUMP_OFF = 4'h8,
        GLYPH_UNKNOWN  = 4'hF
    } glyph_e;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMMIT  = 2'd2
    } scan_state_e;

    // Row-major masks: bits [5r+4:5r] = columns of row r+1, bit0 = column 1.
    localparam logic [NPIX-1:0] ROWS_BLANK    = '0;
    localparam logic [NPIX-1:0] ROWS_LVL_LOW  = {5'h00, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F};
    localparam logic [NPIX-1:0] ROWS_LVL_MED  = {5'h00, 5'h1F, 5'h1F, 5'h00, 5'h1F, 5'h1F, 5'h1F};
    localparam logic [NPIX-1:0] ROWS_LVL_HIGH = {5'h00, 5'h1F, 5'h1F, 5'h00, 5'h1F, 5'h1F, 5'h00};
    localparam logic [NPIX-1:0] ROWS_CRIT     = {5'h00, 5'h1E, 5'h1E, 5'h00, 5'h1E, 5'h1E, 5'h00};
    localparam logic [NPIX-1:0] ROWS_ERR      = {5'h00, 5'h1E, 5'h1E, 5'h1E, 5'h1E, 5'h1E, 5'h00};
    localparam logic [NPIX-1:0] ROWS_PUMP_A   = {5'h0E, 5'h0E, 5'h00, 5'h0E, 5'h0E, 5'h0E, 5'h00};
    localparam logic [NPIX-1:0] ROWS_PUMP_G   = {5'h00, 5'h0E, 5'h0E, 5'h06, 5'h1E, 5'h1E, 5'h00};
    localparam logic [NPIX-1:0] ROWS_PUMP_OFF = {5'h00, 5'h0E, 5'h0E, 5'h0E, 5'h0E, 5'h0E, 5'h00};

    // Transpose a row-major mask into the column-major frame layout.
    function automatic logic [NPIX-1:0] rows_to_frame(input logic [NPIX-1:0] rows);
        logic [NPIX-1:0] f;
        f = '0;
        for (int c = 0; c < NCOL; c++) begin
            for (int r = 0; r < NROW; r++) begin
                f[c*NROW + r] = rows[r*NCOL + c];
            end
        end
        return f;
    endfunction

    function automatic glyph_e decode(input logic [NPIX-1:0] frame);
        if (frame == rows_to_frame(ROWS_BLANK))    return GLYPH_BLANK;
        if (frame == rows_to_frame(ROWS_LVL_LOW))  return GLYPH_LVL_LOW;
        if (frame == rows_to_frame(ROWS_LVL_MED))  return GLYPH_LVL_MED;
        if (frame == rows_to_frame(ROWS_LVL_HIGH)) return GLYPH_LVL_HIGH;
        if (frame == rows_to_frame(ROWS_CRIT))     return GLYPH_CRIT;
        if (frame == rows_to_frame(ROWS_ERR))      return GLYPH_ERR;
        if (frame == rows_to_frame(ROWS_PUMP_A))   return GLYPH_PUMP_A;
        if (frame == rows_to_frame(ROWS_PUMP_G))   return GLYPH_PUMP_G;
        if (frame == rows_to_frame(ROWS_PUMP_OFF)) return GLYPH_PUMP_OFF;
        return GLYPH_UNKNOWN;
    endfunction

endpackage

// File: rtl/matrix_scan_decoder_scan_qualifier.sv
// Column settle filter: strobes once when a column value has been stable for
// SETTLE_CYC consecutive cycles, classified as a single column or multi-hot.
module scan_qualifier
    import matrix_pkg::*;
#(
    parameter int SETTLE_CYC = 4
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [NCOL-1:0] col_i,
    output logic            col_chg_o,
    output logic            col_qual_o,
    output logic            multi_qual_o,
    output logic [2:0]      col_idx_o
);

    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] SETTLE = CW'(SETTLE_CYC);

    logic [NCOL-1:0] prev_q;
    logic [CW-1:0]   run_q, run_d;
    logic            settle_hit;

    always_comb begin
        col_chg_o = (col_i != prev_q);
        if (col_chg_o) begin
            run_d = CW'(1);
        end else if (run_q != SETTLE) begin
            run_d = run_q + 1'b1;
        end else begin
            run_d = run_q;
        end
        // Saturation keeps the strobe to exactly one cycle per stable stretch.
        settle_hit = (run_d == SETTLE) && (col_chg_o || (run_q != SETTLE));

        col_idx_o = 3'd0;
        for (int i = 0; i < NCOL; i++) begin
            if (col_i[i]) col_idx_o = 3'(i);
        end

        col_qual_o   = settle_hit && $onehot(col_i);
        multi_qual_o = settle_hit && ($countones(col_i) > 1);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            prev_q <= '0;
            run_q  <= '0;
        end else begin
            prev_q <= col_i;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/matrix_scan_decoder.sv
// Rebuilds 5x7 matrix frames from the scan lines, checks the column order and
// reports a confirmed glyph. Define MATRIX_SYNC_EN for an asynchronous driver.
module matrix_scan_decoder
    import matrix_pkg::*;
#(
    parameter int SETTLE_CYC    = 4,
    parameter int TIMEOUT_CYC   = 1024,
    parameter int STABLE_FRAMES = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NCOL-1:0] col_i,
    input  logic [NROW-1:0] lin_i,
    output logic [NPIX-1:0] frame_o,
    output logic            frame_valid,
    output logic [3:0]      symbol,
    output logic            symbol_valid,
    output logic            scan_err,
    output scan_state_e     dbg_state_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int MW = $clog2(STABLE_FRAMES + 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYC);
    localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_FRAMES);
    localparam logic [2:0]    LAST_COL  = 3'(NCOL - 1);

    logic [NCOL-1:0] col_s;
    logic [NROW-1:0] lin_s;

`ifdef MATRIX_SYNC_EN
    logic [NCOL-1:0] col_m_q, col_s_q;
    logic [NROW-1:0] lin_m_q, lin_s_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_m_q <= '0;
            col_s_q <= '0;
            lin_m_q <= '0;
            lin_s_q <= '0;
        end else begin
            col_m_q <= col_i;
            col_s_q <= col_m_q;
            lin_m_q <= lin_i;
            lin_s_q <= lin_m_q;
        end
    end

    assign col_s = col_s_q;
    assign lin_s = lin_s_q;
`else
    assign col_s = col_i;
    assign lin_s = lin_i;
`endif

    logic       col_chg, col_qual, multi_qual;
    logic [2:0] col_idx;

    scan_qualifier #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_qual (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .col_i        (col_s),
        .col_chg_o    (col_chg),
        .col_qual_o   (col_qual),
        .multi_qual_o (multi_qual),
        .col_idx_o    (col_idx)
    );

    scan_state_e            state_q;
    logic [2:0]             col_exp_q;
    logic [NPIX-NROW-1:0]   shadow_q;
    logic [NPIX-1:0]        frame_q;
    logic                   frame_valid_q, symbol_valid_q, scan_err_q;
    logic [3:0]             symbol_q;
    logic [MW-1:0]          match_q, match_d;
    logic [TW-1:0]          tmo_q, tmo_inc;
    logic [NPIX-1:0]        new_frame;
    logic                   tmo_hit;

    always_comb begin
        // Column 5 is merged straight from the lines so the commit lands one
        // cycle after its capture.
        new_frame = {lin_s, shadow_q};
        tmo_inc   = tmo_q + 1'b1;
        tmo_hit   = (state_q == ST_CAPTURE) && (tmo_inc == TMO_MAX);
        if (new_frame != frame_q) begin
            match_d = MW'(1);
        end else if (match_q != MATCH_MAX) begin
            match_d = match_q + 1'b1;
        end else begin
            match_d = match_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_HUNT;
            col_exp_q      <= 3'd0;
            shadow_q       <= '0;
            frame_q        <= '0;
            frame_valid_q  <= 1'b0;
            symbol_q       <= 4'h0;
            symbol_valid_q <= 1'b0;
            scan_err_q     <= 1'b0;
            match_q        <= '0;
            tmo_q          <= '0;
        end else begin
            frame_valid_q <= 1'b0;
            scan_err_q    <= 1'b0;
            case (state_q)
                ST_CAPTURE: begin
                    tmo_q <= col_chg ? TW'(1) : tmo_inc;
                    if (tmo_hit || multi_qual || (col_qual && col_idx != col_exp_q
                                                  && col_idx != col_exp_q - 3'd1)) begin
                        scan_err_q     <= 1'b1;
                        symbol_valid_q <= 1'b0;
                        match_q        <= '0;
                        shadow_q       <= '0;
                        tmo_q          <= '0;
                        state_q        <= ST_HUNT;
                    end else if (col_qual && col_idx == col_exp_q) begin
                        if (col_exp_q == LAST_COL) begin
                            frame_q       <= new_frame;
                            frame_valid_q <= 1'b1;
                            match_q       <= match_d;
                            if (match_d >= MATCH_MAX) begin
                                symbol_q       <= decode(new_frame);
                                symbol_valid_q <= 1'b1;
                            end
                            tmo_q   <= '0;
                            state_q <= ST_COMMIT;
                        end else begin
                            shadow_q[int'(col_exp_q)*NROW +: NROW] <= lin_s;
                            col_exp_q <= col_exp_q + 3'd1;
                        end
                    end
                end
                default: begin
                    // HUNT and the one-cycle COMMIT both wait for column 1.
                    state_q <= ST_HUNT;
                    tmo_q   <= '0;
                    if (multi_qual) begin
                        scan_err_q     <= 1'b1;
                        symbol_valid_q <= 1'b0;
                        match_q        <= '0;
                        shadow_q       <= '0;
                    end else if (col_qual && col_idx == 3'd0) begin
                        shadow_q[NROW-1:0] <= lin_s;
                        col_exp_q          <= 3'd1;
                        tmo_q              <= TW'(SETTLE_CYC);
                        state_q            <= ST_CAPTURE;
                    end
                end
            endcase
        end
    end

    assign frame_o      = frame_q;
    assign frame_valid  = frame_valid_q;
    assign symbol       = symbol_q;
    assign symbol_valid = symbol_valid_q;
    assign scan_err     = scan_err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_matrix_scan_decoder.sv
// Bench for matrix_scan_decoder: glyph table scanned frame by frame with a
// scoreboard on frame_valid, plus hand sequences for errors, timeout and reset.
module tb_matrix_scan_decoder;

    localparam int SETTLE = 4;
    localparam int TMO    = 1024;
    localparam int STABLE = 2;
    localparam int GAP    = 2;
    localparam int NVEC   = 20;

    typedef logic [6:0][4:0] rows_t;   // rows_t[r] = column mask of row r+1
    typedef struct packed {
        rows_t      rows;
        logic [3:0] sym;
        logic       vld;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  col_i;
    logic [6:0]  lin_i;
    logic [34:0] frame_o;
    logic        frame_valid;
    logic [3:0]  symbol;
    logic        symbol_valid;
    logic        scan_err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;
    int errs_seen = 0;
    logic [39:0] exp_q[$];
    logic [39:0] mon_e;
    vec_t        tbl[NVEC];

    always #5 clk = ~clk;

    matrix_scan_decoder #(
        .SETTLE_CYC    (SETTLE),
        .TIMEOUT_CYC   (TMO),
        .STABLE_FRAMES (STABLE)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .col_i        (col_i),
        .lin_i        (lin_i),
        .frame_o      (frame_o),
        .frame_valid  (frame_valid),
        .symbol       (symbol),
        .symbol_valid (symbol_valid),
        .scan_err     (scan_err),
        .dbg_state_o  (dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic rows_t mk(input logic [4:0] r1, r2, r3, r4, r5, r6, r7);
        rows_t r;
        r[0] = r1; r[1] = r2; r[2] = r3; r[3] = r4;
        r[4] = r5; r[5] = r6; r[6] = r7;
        return r;
    endfunction

    function automatic rows_t glyph(input int code);
        case (code)
            1:       return mk(5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h00);
            2:       return mk(5'h1F, 5'h1F, 5'h1F, 5'h00, 5'h1F, 5'h1F, 5'h00);
            3:       return mk(5'h00, 5'h1F, 5'h1F, 5'h00, 5'h1F, 5'h1F, 5'h00);
            4:       return mk(5'h00, 5'h1E, 5'h1E, 5'h00, 5'h1E, 5'h1E, 5'h00);
            5:       return mk(5'h00, 5'h1E, 5'h1E, 5'h1E, 5'h1E, 5'h1E, 5'h00);
            6:       return mk(5'h00, 5'h0E, 5'h0E, 5'h0E, 5'h00, 5'h0E, 5'h0E);
            7:       return mk(5'h00, 5'h1E, 5'h1E, 5'h06, 5'h0E, 5'h0E, 5'h00);
            8:       return mk(5'h00, 5'h0E, 5'h0E, 5'h0E, 5'h0E, 5'h0E, 5'h00);
            default: return mk(5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        endcase
    endfunction

    function automatic logic [3:0] tb_decode(input rows_t rows);
        for (int g = 0; g <= 8; g++) begin
            if (rows == glyph(g)) return 4'(g);
        end
        return 4'hF;
    endfunction

    function automatic logic [6:0] lines_of(input rows_t rows, input int c);
        logic [6:0] l;
        for (int r = 0; r < 7; r++) l[r] = rows[r][c];
        return l;
    endfunction

    function automatic logic [34:0] to_frame(input rows_t rows);
        logic [34:0] f;
        for (int c = 0; c < 5; c++) f[7*c +: 7] = lines_of(rows, c);
        return f;
    endfunction

    function automatic vec_t mkvec(input rows_t rows, input logic [3:0] sym, input logic vld);
        vec_t v;
        v.rows = rows; v.sym = sym; v.vld = vld;
        return v;
    endfunction

    task automatic cyc(input logic [4:0] c, input logic [6:0] l, input int n);
        repeat (n) begin
            col_i = c;
            lin_i = l;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_col(input int c, input rows_t rows);
        cyc(5'(1 << c), lines_of(rows, c), SETTLE);
        cyc(5'h00, 7'h00, GAP);
    endtask

    task automatic scan_frame(input rows_t rows);
        for (int c = 0; c < 5; c++) drive_col(c, rows);
    endtask

    task automatic expect_frame(input rows_t rows, input logic [3:0] sym, input logic vld);
        exp_q.push_back({to_frame(rows), sym, vld});
    endtask

    // Scoreboard: every frame_valid pulse consumes one expected record.
    always @(posedge clk) begin
        #1;
        if (scan_err) errs_seen++;
        if (frame_valid) begin
            frames_seen++;
            check("err_frame_exclusive", 64'(scan_err), 64'(0));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame actual=%0h expected=none", frame_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("frame", 64'(frame_o), 64'(mon_e[39:5]));
                check("symbol", 64'(symbol), 64'(mon_e[4:1]));
                check("symbol_valid", 64'(symbol_valid), 64'(mon_e[0]));
            end
        end
    end

    initial begin
        rows_t odd, rnd;
        int f0, e0, hit_n;

        odd = mk(5'h15, 5'h0A, 5'h15, 5'h0A, 5'h15, 5'h0A, 5'h15);
        tbl[0]  = mkvec(glyph(1), 4'h0, 1'b0);
        tbl[1]  = mkvec(glyph(1), 4'h1, 1'b1);
        tbl[2]  = mkvec(glyph(6), 4'h1, 1'b1);
        tbl[3]  = mkvec(glyph(6), 4'h6, 1'b1);
        tbl[4]  = mkvec(glyph(2), 4'h6, 1'b1);
        tbl[5]  = mkvec(glyph(2), 4'h2, 1'b1);
        tbl[6]  = mkvec(glyph(3), 4'h2, 1'b1);
        tbl[7]  = mkvec(glyph(3), 4'h3, 1'b1);
        tbl[8]  = mkvec(glyph(4), 4'h3, 1'b1);
        tbl[9]  = mkvec(glyph(4), 4'h4, 1'b1);
        tbl[10] = mkvec(glyph(5), 4'h4, 1'b1);
        tbl[11] = mkvec(glyph(5), 4'h5, 1'b1);
        tbl[12] = mkvec(glyph(7), 4'h5, 1'b1);
        tbl[13] = mkvec(glyph(7), 4'h7, 1'b1);
        tbl[14] = mkvec(glyph(8), 4'h7, 1'b1);
        tbl[15] = mkvec(glyph(8), 4'h8, 1'b1);
        tbl[16] = mkvec(glyph(0), 4'h8, 1'b1);
        tbl[17] = mkvec(glyph(0), 4'h0, 1'b1);
        tbl[18] = mkvec(odd,      4'h0, 1'b1);
        tbl[19] = mkvec(odd,      4'hF, 1'b1);

        // Clock/reset
        rstn  = 1'b0;
        col_i = 5'h00;
        lin_i = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_frame", 64'(frame_o), 64'(0));
        check("rst_frame_valid", 64'(frame_valid), 64'(0));
        check("rst_symbol", 64'(symbol), 64'(0));
        check("rst_symbol_valid", 64'(symbol_valid), 64'(0));
        check("rst_scan_err", 64'(scan_err), 64'(0));
        rstn = 1'b1;
        cyc(5'h00, 7'h00, 2);

        // Glyph table
        for (int i = 0; i < NVEC; i++) begin
            expect_frame(tbl[i].rows, tbl[i].sym, tbl[i].vld);
            scan_frame(tbl[i].rows);
        end
        check("table_frames", 64'(frames_seen), 64'(NVEC));
        check("table_no_err", 64'(errs_seen), 64'(0));

        // Column order 1,2,4
        f0 = frames_seen;
        drive_col(0, glyph(3));
        drive_col(1, glyph(3));
        cyc(5'b01000, lines_of(glyph(3), 3), SETTLE - 1);
        check("order_no_early_err", 64'(scan_err), 64'(0));
        cyc(5'b01000, lines_of(glyph(3), 3), 1);
        check("order_err", 64'(scan_err), 64'(1));
        check("order_symbol_valid", 64'(symbol_valid), 64'(0));
        check("order_symbol_kept", 64'(symbol), 64'hF);
        cyc(5'h00, 7'h00, GAP);
        check("order_err_pulse", 64'(scan_err), 64'(0));
        check("order_no_frame", 64'(frames_seen), 64'(f0));
        expect_frame(glyph(1), 4'hF, 1'b0);
        scan_frame(glyph(1));
        expect_frame(glyph(1), 4'h1, 1'b1);
        scan_frame(glyph(1));

        // Timeout on a held column 3
        f0 = frames_seen;
        e0 = errs_seen;
        hit_n = -1;
        drive_col(0, glyph(2));
        drive_col(1, glyph(2));
        for (int n = 1; n <= TMO + 8; n++) begin
            cyc(5'b00100, lines_of(glyph(2), 2), 1);
            if (scan_err && hit_n < 0) hit_n = n;
        end
        check("timeout_cycle", 64'(hit_n), 64'(TMO));
        check("timeout_err_count", 64'(errs_seen - e0), 64'(1));
        check("timeout_symbol_valid", 64'(symbol_valid), 64'(0));
        check("timeout_no_frame", 64'(frames_seen), 64'(f0));
        cyc(5'h00, 7'h00, GAP);

        // Glitch to column 5 inside column 2, random non-glyph pattern
        for (int r = 0; r < 7; r++) rnd[r] = 5'($urandom_range(0, 31));
        rnd[0] = 5'h15;
        expect_frame(rnd, 4'h1, 1'b0);
        drive_col(0, rnd);
        cyc(5'b00010, lines_of(rnd, 1), SETTLE - 1);
        cyc(5'b10000, 7'($urandom_range(0, 127)), 2);
        cyc(5'b00010, lines_of(rnd, 1), SETTLE);
        cyc(5'h00, 7'h00, GAP);
        for (int c = 2; c < 5; c++) drive_col(c, rnd);
        expect_frame(rnd, tb_decode(rnd), 1'b1);
        scan_frame(rnd);

        // Reset mid-frame, then a scan that starts at column 2
        drive_col(0, glyph(7));
        drive_col(1, glyph(7));
        cyc(5'b00100, lines_of(glyph(7), 2), 2);
        rstn = 1'b0;
        #2;
        check("midrst_frame", 64'(frame_o), 64'(0));
        check("midrst_symbol", 64'(symbol), 64'(0));
        check("midrst_symbol_valid", 64'(symbol_valid), 64'(0));
        check("midrst_frame_valid", 64'(frame_valid), 64'(0));
        check("midrst_scan_err", 64'(scan_err), 64'(0));
        @(posedge clk);
        #1;
        cyc(5'h00, 7'h00, 2);
        rstn = 1'b1;
        cyc(5'h00, 7'h00, 2);
        f0 = frames_seen;
        e0 = errs_seen;
        for (int c = 1; c < 5; c++) drive_col(c, glyph(3));
        check("late_start_no_frame", 64'(frames_seen), 64'(f0));
        check("late_start_no_err", 64'(errs_seen), 64'(e0));
        expect_frame(glyph(3), 4'h0, 1'b0);
        scan_frame(glyph(3));
        check("post_rst_frame", 64'(frames_seen), 64'(f0 + 1));

        cyc(5'h00, 7'h00, 4);
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
